skin_segment_tx: RTL and testbench
==================================

Name: skin_segment_tx

Overview:
- Transmit end of the binary object-pixel stream consumed by the palm identification stage.
- Accepts camera chroma pixels (Cb, Cr) in raster order and classifies each pixel as skin or non-skin with fixed window thresholds.
- Emits one `object_image` bit per pixel over a valid/ready interface, tagged with row/col and frame markers, through a small output FIFO.
- Reports a per-frame object-pixel count and a sticky sync-error flag.

Parameters:
- IMG_W, 160, pixels per row (2..256)
- IMG_H, 120, rows per frame (2..256)
- CB_MIN, 77, lower Cb skin bound, inclusive
- CB_MAX, 127, upper Cb skin bound, inclusive
- CR_MIN, 133, lower Cr skin bound, inclusive
- CR_MAX, 173, upper Cr skin bound, inclusive
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel this cycle
- in_sof  in  1  qualifies input pixel as first of frame
- in_cb  in  8  Cb component
- in_cr  in  8  Cr component
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- object_image  out  1  1 = skin pixel
- out_row  out  8  row of head pixel
- out_col  out  8  column of head pixel
- out_sof  out  1  head is row 0, col 0
- out_eol  out  1  head is col IMG_W-1
- out_eof  out  1  head is last pixel of frame
- frame_done  out  1  one-cycle pulse, frame fully drained
- obj_count  out  16  object pixels in last completed frame
- sync_err  out  1  sticky: in_sof seen mid-frame

Behaviour:
- Input transfer occurs when `in_valid & in_ready`. Output transfer occurs when `out_valid & out_ready`.
- Classification: obj = (CB_MIN<=cb<=CB_MAX) & (CR_MIN<=cr<=CR_MAX), unsigned compares. It is evaluated at input transfer and stored in the FIFO entry {obj,row,col,sof,eol,eof}.
- `out_valid` = FIFO not empty. The head entry drives all out_* signals and `object_image`.
- Latency: a pixel accepted in cycle N is presented at the output in cycle N+1 if the FIFO was empty.
- `in_ready` = FIFO not full AND state != DRAIN. There is no push-through when full, even if a pop occurs in the same cycle.
- A simultaneous push and pop when FIFO is neither full nor empty keeps occupancy unchanged.
- Column/row counters (8 bit):
  - col increments per accepted STREAM pixel.
  - At col==IMG_W-1, col wraps to 0 and row increments.
  - Counters never reach IMG_W or IMG_H.
- State machine:
  - IDLE: `in_ready`=1 (FIFO permitting). Pixels without `in_sof` are accepted and discarded. A transfer with `in_sof` is stored as row 0, col 0 with sof=1, the running count is loaded with obj, and the state goes to STREAM.
  - STREAM: each transfer is pushed and counted. A transfer at row IMG_H-1, col IMG_W-1 is pushed with eof=1 (and eol=1), and the state goes to DRAIN.
  - STREAM with `in_sof` on a transfer not at row 0, col 0: `sync_err` is set, and the pixel is stored as row 0, col 0 of a new frame with sof=1. The running count restarts. No `frame_done` is issued for the aborted frame.
  - DRAIN: `in_ready`=0. When the FIFO becomes empty (the eof entry has been popped), `frame_done` pulses one cycle, `obj_count` is loaded with the running count, and the state goes to IDLE.
- The running count is 16 bits (max 65536 fits IMG_W*IMG_H only up to 65535; saturate at 16'hFFFF).
- `obj_count` holds its value until the next `frame_done`.
- `sync_err` clears only on reset.
- Reset (asynchronous assert, any state):
  - state=IDLE, FIFO empty, counters 0, running count 0.
  - `out_valid`=0, `object_image`=0, `out_row`/`out_col`=0, `out_sof`/`out_eol`/`out_eof`=0.
  - `frame_done`=0, `obj_count`=0, `sync_err`=0.
  - A frame in flight is discarded and not resumed.
- Out_* signals are registered FIFO outputs. They are stable while `out_valid & !out_ready`.

Test Plan:
- Reset/idle:
  - Stimulus: hold `rst`=0, then release with no input.
  - Required: all outputs 0; `in_ready`=1; `out_valid`=0 indefinitely.
- Small frame (IMG_W=4, IMG_H=2), `out_ready`=1, in_sof on first pixel, all pixels cb=100, cr=150:
  - Required: 8 outputs with `object_image`=1.
  - Rows/cols in order (0,0)..(1,3).
  - sof on first, eol on cols 3, eof on 8th.
  - `frame_done` pulse once, `obj_count`=8.
- Threshold edges:
  - cb=77/cr=133 -> 1.
  - cb=76/cr=150 -> 0.
  - cb=127/cr=173 -> 1.
  - cb=100/cr=174 -> 0.
- Backpressure, `out_ready`=0 with continuous `in_valid`:
  - Required: exactly 4 accepts, then `in_ready`=0.
  - Release `out_ready`: all pixels emerge in order, none lost or duplicated.
- Mid-frame sync (IMG_W=4, IMG_H=2): `in_sof` on 3rd pixel.
  - Required: `sync_err`=1 sticky; that pixel emitted as row 0, col 0 with sof.
  - `frame_done` only after 8 further-counted pixels; `obj_count` reflects new frame only.
- Reset mid-frame:
  - Stimulus: assert `rst` after 5 pixels with FIFO holding 2 entries.
  - Required: `out_valid` drops immediately; counts and flags 0.
  - Next `in_sof` frame runs normally with `obj_count` correct.

Source files
------------

// File: rtl/skin_segment_tx_if.sv
// rtl/skin_segment_tx_if.sv - pixel input and object-bit output handshake bundle
interface skin_segment_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_sof;
  logic [7:0] in_cb;
  logic [7:0] in_cr;
  logic       out_valid;
  logic       out_ready;
  logic       object_image;
  logic [7:0] out_row;
  logic [7:0] out_col;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;

  modport master (
    output in_valid, in_sof, in_cb, in_cr, out_ready,
    input  in_ready, out_valid, object_image, out_row, out_col, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_sof, in_cb, in_cr, out_ready,
    output in_ready, out_valid, object_image, out_row, out_col, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/skin_segment_tx.sv
// rtl/skin_segment_tx.sv - chroma skin classifier with framed object-bit output FIFO
module skin_segment_tx #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int CB_MIN     = 77,
  parameter int CB_MAX     = 127,
  parameter int CR_MIN     = 133,
  parameter int CR_MAX     = 173,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  skin_segment_tx_if.slave    bus,
  output logic                frame_done,
  output logic [15:0]         obj_count,
  output logic                sync_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] COL_LAST = 8'(IMG_W - 1);
  localparam logic [7:0] ROW_LAST = 8'(IMG_H - 1);
  localparam logic [7:0] CB_LO = 8'(CB_MIN);
  localparam logic [7:0] CB_HI = 8'(CB_MAX);
  localparam logic [7:0] CR_LO = 8'(CR_MIN);
  localparam logic [7:0] CR_HI = 8'(CR_MAX);
  localparam logic [AW:0] FILL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [19:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fill;
  logic [7:0]    row, col, row_nxt, col_nxt;
  logic [7:0]    ent_row, ent_col;
  logic          ent_eol, ent_eof;
  logic [15:0]   run, run_nxt;
  logic          empty, full, accept, pop, obj;
  logic          push, restart, set_err, done_set;
  logic [19:0]   head;

  assign empty        = (fill == '0);
  assign full         = (fill == FILL_FULL);
  assign bus.in_ready = !full && (state != DRAIN);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;
  assign obj          = (bus.in_cb >= CB_LO) && (bus.in_cb <= CB_HI) &&
                        (bus.in_cr >= CR_LO) && (bus.in_cr <= CR_HI);

  // Head entry layout: {obj, row, col, sof, eol, eof}
  assign head             = mem[rd_ptr];
  assign bus.out_valid    = !empty;
  assign bus.object_image = head[19];
  assign bus.out_row      = head[18:11];
  assign bus.out_col      = head[10:3];
  assign bus.out_sof      = head[2];
  assign bus.out_eol      = head[1];
  assign bus.out_eof      = head[0];

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    restart   = 1'b0;
    set_err   = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && bus.in_sof) begin
          push    = 1'b1;
          restart = 1'b1;
        end
      end
      STREAM: begin
        if (accept) begin
          push = 1'b1;
          // A new sof mid-frame abandons the current frame and starts over
          if (bus.in_sof && (row != '0 || col != '0)) begin
            restart = 1'b1;
            set_err = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (empty) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    ent_row = restart ? 8'd0 : row;
    ent_col = restart ? 8'd0 : col;
    ent_eol = (ent_col == COL_LAST);
    ent_eof = ent_eol && (ent_row == ROW_LAST);
    if (push) state_nxt = ent_eof ? DRAIN : STREAM;

    col_nxt = ent_eol ? 8'd0 : ent_col + 8'd1;
    row_nxt = ent_row;
    if (ent_eol) row_nxt = (ent_row == ROW_LAST) ? 8'd0 : ent_row + 8'd1;

    if (restart)               run_nxt = {15'd0, obj};
    else if (run == 16'hFFFF)  run_nxt = run;
    else                       run_nxt = run + {15'd0, obj};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row        <= '0;
      col        <= '0;
      run        <= '0;
      sync_err   <= 1'b0;
      frame_done <= 1'b0;
      obj_count  <= '0;
    end else begin
      if (push) begin
        row <= row_nxt;
        col <= col_nxt;
        run <= run_nxt;
      end
      sync_err   <= sync_err | set_err;
      frame_done <= done_set;
      if (done_set) obj_count <= run;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {obj, ent_row, ent_col, restart, ent_eol, ent_eof};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_skin_segment_tx.sv
// tb/tb_skin_segment_tx.sv - randomized and directed checks against a frame-index reference model
module tb_skin_segment_tx;
  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_done;
  logic [15:0] obj_count;
  logic        sync_err;

  skin_segment_tx_if bus();

  skin_segment_tx #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .frame_done(frame_done), .obj_count(obj_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 0;

  // Reference model: position within frame is a flat pixel index
  logic [19:0] exp_q[$];
  int          done_q[$];
  bit          in_frame = 0;
  int          idx = 0;
  int          cnt = 0;
  int          last_cnt = 0;
  bit          sync_exp = 0;
  int          frames_exp = 0;
  int          fd_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    checks++;
    assert (cond) else begin
      errors++;
      $error("FAIL %s: condition false, expected true", tag);
    end
  endtask

  function automatic bit is_skin(input int cb, input int cr);
    return cb >= 77 && cb <= 127 && cr >= 133 && cr <= 173;
  endfunction

  task automatic model_accept(input bit sof, input int cb, input int cr);
    bit o;
    if (!in_frame) begin
      if (!sof) return;
      in_frame = 1; idx = 0; cnt = 0;
    end else if (sof && idx != 0) begin
      sync_exp = 1; idx = 0; cnt = 0;
    end
    o = is_skin(cb, cr);
    exp_q.push_back({o, 8'(idx / W), 8'(idx % W), idx == 0, (idx % W) == W - 1, idx == W * H - 1});
    cnt = (cnt + int'(o) > 65535) ? 65535 : cnt + int'(o);
    if (idx == W * H - 1) begin
      done_q.push_back(cnt);
      last_cnt = cnt;
      frames_exp++;
      in_frame = 0;
    end
    idx++;
  endtask

  task automatic cycle(output logic acc);
    logic [19:0] got;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      check_true("out_expected", exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        got = {bus.object_image, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol, bus.out_eof};
        check("out_entry", got, exp_q.pop_front());
      end
    end
    if (frame_done) begin
      fd_seen++;
      check_true("done_expected", done_q.size() != 0);
      if (done_q.size() != 0) check("obj_count_at_done", obj_count, done_q.pop_front());
    end
    if (acc) model_accept(bus.in_sof, bus.in_cb, bus.in_cr);
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input bit sof, input int cb, input int cr, input bit gaps);
    logic acc;
    int n;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.in_sof   = sof;
      bus.in_cb    = 8'(cb);
      bus.in_cr    = 8'(cr);
      cycle(acc);
      n++;
    end
    bus.in_valid = 0;
    bus.in_sof   = 0;
    check_true("send_accepted", acc);
  endtask

  task automatic drain();
    logic acc;
    bus.in_valid = 0;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || done_q.size() != 0); i++) cycle(acc);
    check("drain_out_left", exp_q.size(), 0);
    check("drain_done_left", done_q.size(), 0);
  endtask

  int th_cb[8] = '{77, 76, 127, 100, 78, 128, 100, 200};
  int th_cr[8] = '{133, 150, 173, 174, 132, 150, 133, 200};

  initial begin
    logic acc;
    int accepts;
    int bp_cb[8];
    int bp_cr[8];
    bus.in_valid = 0; bus.in_sof = 0; bus.in_cb = 0; bus.in_cr = 0; bus.out_ready = 0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      check("idle_out_valid", bus.out_valid, 0);
    end
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_outs", {bus.object_image, bus.out_row, bus.out_col, bus.out_sof, bus.out_eol, bus.out_eof}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_obj_count", obj_count, 0);
    check("rst_sync_err", sync_err, 0);

    // Small all-skin frame, preceded by a discarded non-sof pixel
    bus.out_ready = 1;
    send(0, 100, 150, 0);
    for (int i = 0; i < 8; i++) send(i == 0, 100, 150, 0);
    drain();
    check("frame1_count", obj_count, 8);
    check("frame1_done_pulses", fd_seen, 1);

    // Threshold edges
    for (int i = 0; i < 8; i++) send(i == 0, th_cb[i], th_cr[i], 0);
    drain();
    check("thresh_count", obj_count, 3);

    // Backpressure
    for (int i = 0; i < 8; i++) begin
      bp_cb[i] = $urandom_range(60, 140);
      bp_cr[i] = $urandom_range(120, 190);
    end
    bus.out_ready = 0;
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1;
      bus.in_sof   = (accepts == 0);
      bus.in_cb    = 8'(bp_cb[accepts]);
      bus.in_cr    = 8'(bp_cr[accepts]);
      cycle(acc);
      if (acc) accepts++;
    end
    bus.in_valid = 0;
    check("bp_accepts", accepts, 4);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1;
    for (int i = accepts; i < 8; i++) send(0, bp_cb[i], bp_cr[i], 0);
    drain();
    check("bp_count", obj_count, last_cnt);

    // Mid-frame sof
    send(1, 100, 150, 0);
    send(0, 100, 150, 0);
    send(1, 90, 140, 0);
    check("sync_err_set", sync_err, 1);
    for (int i = 0; i < 7; i++) send(0, (i % 2) ? 100 : 50, 150, 0);
    drain();
    check("sync_frame_count", obj_count, 4);
    check("sync_model_count", obj_count, last_cnt);

    // Randomized frames with random gaps and downstream stalls
    rand_ready = 1;
    for (int f = 0; f < 4; f++) begin
      send(0, $urandom_range(0, 255), $urandom_range(0, 255), 1);
      for (int i = 0; i < 8; i++) send(i == 0, $urandom_range(60, 140), $urandom_range(120, 190), 1);
      drain();
      check("rand_count", obj_count, last_cnt);
    end
    rand_ready = 0;
    check("sync_err_sticky", sync_err, sync_exp);
    check("done_pulses_total", fd_seen, frames_exp);

    // Reset with a frame in flight
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) send(i == 0, 100, 150, 0);
    bus.out_ready = 0;
    send(0, 100, 150, 0);
    rst = 0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_obj_count", obj_count, 0);
    check("rst_mid_sync_err", sync_err, 0);
    check("rst_mid_frame_done", frame_done, 0);
    exp_q.delete(); done_q.delete();
    in_frame = 0; sync_exp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) send(i == 0, (i < 5) ? 100 : 20, 150, 0);
    drain();
    check("post_rst_count", obj_count, 5);
    check("post_rst_sync_err", sync_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
